// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap CSRs and interrupt/WFI/MRET sequencer for the RV32 core.
// Drives PC redirect, pipeline flush and stall beside the EX stage.
module csr_trap_ctrl #(
  parameter logic [31:0] MTVEC_BASE = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [1:0]  ex_csr_op,
  input  logic [11:0] ex_csr_addr,
  input  logic [31:0] ex_csr_wdata,
  input  logic        ex_mret,
  input  logic        ex_wfi,
  input  logic        ext_irq,
  input  logic        tmr_irq,
  output logic [31:0] csr_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        stall
);

  // state | meaning
  // RUN   | normal execution, traps/MRET/CSR writes accepted
  // SLEEP | WFI retired, pipeline stalled until an interrupt pends
  // FLUSH | single cycle after any redirect, nothing accepted
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SLEEP = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [31:0] MTVEC    = MTVEC_BASE & ~32'h3;
  localparam logic [11:0] A_STATUS = 12'h300;
  localparam logic [11:0] A_IE     = 12'h304;
  localparam logic [11:0] A_TVEC   = 12'h305;
  localparam logic [11:0] A_EPC    = 12'h341;
  localparam logic [11:0] A_CAUSE  = 12'h342;
  localparam logic [11:0] A_IP     = 12'h344;

  state_t      state;
  logic        mie_b;
  logic        mpie;
  logic        mtie;
  logic        meie;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] wake_pc;
  logic        ext_s1, ext_s2;
  logic        tmr_s1, tmr_s2;

  logic [1:0]  pend;
  logic        irq_any;
  logic        take_irq;
  logic        sleep_trap;
  logic        trap;
  logic        do_mret;
  logic        csr_we;
  logic [31:0] csr_old;
  logic [31:0] csr_new;

  assign pend       = {ext_s2 & meie, tmr_s2 & mtie};
  assign irq_any    = |pend;
  assign take_irq   = ex_valid & mie_b & irq_any & (state == RUN);
  assign sleep_trap = (state == SLEEP) & irq_any & mie_b;
  assign trap       = take_irq | sleep_trap;
  assign do_mret    = (state == RUN) & ex_valid & ex_mret & ~take_irq;
  assign csr_we     = (state == RUN) & ex_valid & ~take_irq & (ex_csr_op != 2'b00);

  always_comb begin
    csr_old = 32'h0;
    case (ex_csr_addr)
      A_STATUS: csr_old = {19'd0, 2'b11, 3'd0, mpie, 3'd0, mie_b, 3'd0};
      A_IE:     csr_old = {20'd0, meie, 3'd0, mtie, 7'd0};
      A_TVEC:   csr_old = MTVEC;
      A_EPC:    csr_old = mepc;
      A_CAUSE:  csr_old = mcause;
      A_IP:     csr_old = {20'd0, ext_s2, 3'd0, tmr_s2, 7'd0};
      default:  csr_old = 32'h0;
    endcase
  end

  always_comb begin
    csr_new = csr_old;
    case (ex_csr_op)
      2'b01:   csr_new = ex_csr_wdata;
      2'b10:   csr_new = csr_old | ex_csr_wdata;
      2'b11:   csr_new = csr_old & ~ex_csr_wdata;
      default: csr_new = csr_old;
    endcase
  end

  // Outputs are held at their reset values while rst is asserted.
  assign csr_rdata   = rst ? 32'h0 : csr_old;
  assign redirect    = ~rst & (trap | do_mret);
  assign flush       = ~rst & (trap | do_mret);
  assign redirect_pc = rst ? 32'h0 : (trap ? MTVEC : (do_mret ? mepc : 32'h0));
  assign stall       = ~rst & (state == SLEEP) & ~irq_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      mie_b   <= 1'b0;
      mpie    <= 1'b0;
      mtie    <= 1'b0;
      meie    <= 1'b0;
      mepc    <= 32'h0;
      mcause  <= 32'h0;
      wake_pc <= 32'h0;
      ext_s1  <= 1'b0;
      ext_s2  <= 1'b0;
      tmr_s1  <= 1'b0;
      tmr_s2  <= 1'b0;
    end else begin
      ext_s1 <= ext_irq;
      ext_s2 <= ext_s1;
      tmr_s1 <= tmr_irq;
      tmr_s2 <= tmr_s1;
      case (state)
        RUN: begin
          if (take_irq) begin
            mepc   <= ex_pc & ~32'h3;
            mcause <= pend[1] ? 32'h8000_000B : 32'h8000_0007;
            mpie   <= mie_b;
            mie_b  <= 1'b0;
            state  <= FLUSH;
          end else if (do_mret) begin
            mie_b  <= mpie;
            mpie   <= 1'b1;
            state  <= FLUSH;
          end else begin
            if (csr_we) begin
              case (ex_csr_addr)
                A_STATUS: begin
                  mie_b <= csr_new[3];
                  mpie  <= csr_new[7];
                end
                A_IE: begin
                  mtie <= csr_new[7];
                  meie <= csr_new[11];
                end
                A_EPC:   mepc   <= csr_new & ~32'h3;
                A_CAUSE: mcause <= csr_new;
                default: ;
              endcase
            end
            if (ex_valid && ex_wfi) begin
              wake_pc <= (ex_pc + 32'd4) & ~32'h3;
              state   <= SLEEP;
            end
          end
        end
        SLEEP: begin
          if (sleep_trap) begin
            mepc   <= wake_pc;
            mcause <= pend[1] ? 32'h8000_000B : 32'h8000_0007;
            mpie   <= mie_b;
            mie_b  <= 1'b0;
            state  <= FLUSH;
          end else if (irq_any) begin
            state  <= RUN;
          end
        end
        FLUSH:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Scoreboard bench for csr_trap_ctrl: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_csr_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [1:0]  ex_csr_op;
  logic [11:0] ex_csr_addr;
  logic [31:0] ex_csr_wdata;
  logic        ex_mret;
  logic        ex_wfi;
  logic        ext_irq;
  logic        tmr_irq;
  logic [31:0] csr_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        stall;

  csr_trap_ctrl dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_csr_op(ex_csr_op),
    .ex_csr_addr(ex_csr_addr), .ex_csr_wdata(ex_csr_wdata),
    .ex_mret(ex_mret), .ex_wfi(ex_wfi),
    .ext_irq(ext_irq), .tmr_irq(tmr_irq),
    .csr_rdata(csr_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .flush(flush), .stall(stall)
  );

  always #5 clk = ~clk;

  localparam int S_RD  = 0;
  localparam int S_RED = 1;
  localparam int S_RPC = 2;
  localparam int S_FLS = 3;
  localparam int S_STL = 4;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;

  always @(posedge clk) cyc_cnt++;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_RD:    return csr_rdata;
      S_RED:   return {31'd0, redirect};
      S_RPC:   return redirect_pc;
      S_FLS:   return {31'd0, flush};
      default: return {31'd0, stall};
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      exp_t e;
      logic [31:0] got;
      e = sb.pop_front();
      checks++;
      if (e.cyc < cyc_cnt) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d never sampled", e.name, e.cyc);
      end else begin
        got = observe(e.sel);
        if (got !== e.val) begin
          errors++;
          $display("FAIL %s: got %h required %h (cycle %0d)", e.name, got, e.val, e.cyc);
        end
      end
    end
  end

  task automatic want(input int sel, input logic [31:0] v, input string n);
    exp_t e;
    e.cyc = cyc_cnt; e.sel = sel; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_csr_op = 2'b00; ex_mret = 1'b0; ex_wfi = 1'b0;
    ex_csr_wdata = 32'h0;
  endtask

  task automatic rd(input logic [11:0] a);
    idle();
    ex_csr_addr = a;
  endtask

  task automatic instr(input logic [31:0] pc, input logic [1:0] op,
                       input logic [11:0] a, input logic [31:0] wd);
    ex_valid = 1'b1; ex_pc = pc; ex_csr_op = op; ex_csr_addr = a;
    ex_csr_wdata = wd; ex_mret = 1'b0; ex_wfi = 1'b0;
  endtask

  task automatic mret(input logic [31:0] pc);
    instr(pc, 2'b00, 12'h000, 32'h0);
    ex_mret = 1'b1;
  endtask

  task automatic wfi(input logic [31:0] pc);
    instr(pc, 2'b00, 12'h000, 32'h0);
    ex_wfi = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ext_irq = 1'b0; tmr_irq = 1'b0; ex_pc = 32'h0; ex_csr_addr = 12'h0;
    idle();

    // outputs held at reset values even with an MRET presented
    step(); mret(32'h10000); ex_csr_addr = 12'h300;
    want(S_RD, 32'h0, "rst_rdata"); want(S_RED, 32'h0, "rst_redirect");
    want(S_FLS, 32'h0, "rst_flush"); want(S_STL, 32'h0, "rst_stall");
    want(S_RPC, 32'h0, "rst_rpc");
    step(); rst = 1'b0; rd(12'h300); want(S_RD, 32'h0000_1800, "mstatus_reset");
    step(); rd(12'h305); want(S_RD, 32'h0001_0000, "mtvec_read");
    step(); rd(12'h341); want(S_RD, 32'h0, "mepc_reset");
    step(); rd(12'h123); want(S_RD, 32'h0, "unimpl_read");

    // CSR arithmetic and masking
    step(); instr(32'h100, 2'b01, 12'h304, 32'hFFFF_FFFF); want(S_RD, 32'h0, "mie_old");
    step(); instr(32'h104, 2'b11, 12'h304, 32'h80); want(S_RD, 32'h880, "mie_masked");
    step(); rd(12'h304); want(S_RD, 32'h800, "mie_cleared");
    step(); instr(32'h108, 2'b01, 12'h341, 32'h123); want(S_RD, 32'h0, "mepc_old");
    step(); rd(12'h341); want(S_RD, 32'h120, "mepc_masked");
    step(); instr(32'h10C, 2'b01, 12'h305, 32'h0);
    step(); rd(12'h305); want(S_RD, 32'h0001_0000, "mtvec_ro");

    // external interrupt trap, then MRET
    step(); instr(32'h110, 2'b10, 12'h300, 32'h8); want(S_RD, 32'h1800, "mstatus_pre_set");
    step(); rd(12'h300); want(S_RD, 32'h1808, "mstatus_mie_set");
    step(); idle(); ext_irq = 1'b1; want(S_RED, 32'h0, "ext_sync0");
    step(); idle(); want(S_RED, 32'h0, "ext_sync1");
    step(); instr(32'h200, 2'b00, 12'h344, 32'h0);
    want(S_RED, 32'h1, "ext_trap_redirect"); want(S_RPC, 32'h0001_0000, "ext_trap_pc");
    want(S_FLS, 32'h1, "ext_trap_flush"); want(S_RD, 32'h800, "mip_meip");
    step(); instr(32'h204, 2'b00, 12'h341, 32'h0);
    want(S_RED, 32'h0, "flush_cycle_redirect"); want(S_FLS, 32'h0, "flush_cycle_flush");
    want(S_RD, 32'h200, "ext_mepc");
    step(); rd(12'h342); ext_irq = 1'b0; want(S_RD, 32'h8000_000B, "ext_mcause");
    step(); rd(12'h300); want(S_RD, 32'h1880, "trap_mstatus");
    step(); idle();
    step(); mret(32'h10010);
    want(S_RED, 32'h1, "mret_redirect"); want(S_RPC, 32'h200, "mret_pc");
    want(S_FLS, 32'h1, "mret_flush");
    step(); rd(12'h300); want(S_RD, 32'h1888, "mret_mstatus"); want(S_RED, 32'h0, "post_mret");

    // both interrupts plus mstatus write in the same cycle
    step(); instr(32'h120, 2'b01, 12'h304, 32'h880); want(S_RD, 32'h800, "mie_old2");
    step(); idle(); ext_irq = 1'b1; tmr_irq = 1'b1; rd(12'h304); want(S_RD, 32'h880, "mie_both");
    step(); idle();
    step(); instr(32'h400, 2'b10, 12'h300, 32'h8);
    want(S_RED, 32'h1, "both_trap"); want(S_RPC, 32'h0001_0000, "both_trap_pc");
    want(S_RD, 32'h1888, "both_old_mstatus");
    step(); instr(32'h404, 2'b00, 12'h300, 32'h0); tmr_irq = 1'b0;
    want(S_RED, 32'h0, "both_flush_no_trap"); want(S_RD, 32'h1880, "write_dropped");
    step(); rd(12'h342); want(S_RD, 32'h8000_000B, "ext_priority");
    // MRET with ext still pending but MIE=0; FLUSH must then refuse the trap
    step(); mret(32'h10020); want(S_RED, 32'h1, "mret2"); want(S_RPC, 32'h400, "mret2_pc");
    step(); instr(32'h500, 2'b00, 12'h300, 32'h0);
    want(S_RED, 32'h0, "flush_blocks_trap"); want(S_RD, 32'h1888, "mret2_mstatus");
    step(); instr(32'h504, 2'b00, 12'h000, 32'h0); ext_irq = 1'b0;
    want(S_RED, 32'h1, "trap_after_flush"); want(S_RPC, 32'h0001_0000, "trap_after_flush_pc");
    step(); rd(12'h341); want(S_RD, 32'h504, "mepc_after_flush");
    step(); idle();
    step(); idle();
    step(); mret(32'h10030); want(S_RED, 32'h1, "mret3"); want(S_RPC, 32'h504, "mret3_pc");
    step(); rd(12'h300); want(S_RD, 32'h1888, "mret3_mstatus");

    // WFI with MIE=1, timer wakes into a trap
    step(); wfi(32'h300); want(S_STL, 32'h0, "wfi_ex_stall"); want(S_RED, 32'h0, "wfi_ex_redirect");
    for (int i = 1; i <= 10; i++) begin
      step(); idle(); want(S_STL, 32'h1, "sleep_stall");
      if (i == 10) tmr_irq = 1'b1;
    end
    step(); idle(); want(S_STL, 32'h1, "sleep_sync");
    step(); idle();
    want(S_STL, 32'h0, "wake_stall"); want(S_RED, 32'h1, "wake_redirect");
    want(S_RPC, 32'h0001_0000, "wake_pc"); want(S_FLS, 32'h1, "wake_flush");
    step(); rd(12'h341); tmr_irq = 1'b0; want(S_RD, 32'h304, "wfi_mepc"); want(S_RED, 32'h0, "wake_flush_cycle");
    step(); rd(12'h342); want(S_RD, 32'h8000_0007, "tmr_mcause");
    step(); rd(12'h300); want(S_RD, 32'h1880, "wfi_trap_mstatus");
    step(); idle();

    // WFI with MIE=0: wake resumes without redirect
    step(); wfi(32'h300); want(S_STL, 32'h0, "wfi2_ex_stall");
    for (int i = 1; i <= 3; i++) begin
      step(); idle(); want(S_STL, 32'h1, "sleep2_stall");
      if (i == 3) tmr_irq = 1'b1;
    end
    step(); idle(); want(S_STL, 32'h1, "sleep2_sync");
    step(); idle();
    want(S_STL, 32'h0, "wake2_stall"); want(S_RED, 32'h0, "wake2_no_redirect");
    want(S_FLS, 32'h0, "wake2_no_flush");
    step(); rd(12'h300); tmr_irq = 1'b0;
    want(S_RD, 32'h1880, "wake2_mstatus"); want(S_STL, 32'h0, "run_after_wake2");

    // reset while asleep
    step(); idle();
    step(); idle();
    step(); idle();
    step(); wfi(32'h600);
    step(); idle(); want(S_STL, 32'h1, "sleep3_stall");
    step(); idle(); rst = 1'b1; #2; rst = 1'b0; rd(12'h300);
    want(S_STL, 32'h0, "rst_sleep_stall"); want(S_RD, 32'h1800, "rst_sleep_mstatus");
    want(S_RED, 32'h0, "rst_sleep_redirect");
    step(); rd(12'h304); want(S_RD, 32'h0, "rst_sleep_mie");
    step(); idle();
    step();

    if (sb.size() != 0) begin
      foreach (sb[i]) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation left unchecked", sb[i].name);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Machine-mode trap and interrupt sequencer for the five-stage RV32 core. It owns the trap CSRs mstatus, mie, mip, mtvec, mepc and mcause, and serves CSR read/write instructions that address them. It also decides when an external or timer interrupt is taken, sequences WFI sleep and MRET return, and drives pipeline redirect, flush and stall. It sits beside the EX stage and feeds the PC-select and hazard logic.

## Interface
- MTVEC_BASE, 32'h0001_0000: trap vector; mtvec reads this value and ignores writes; bits [1:0] are forced 0 (direct mode).
- clk  in  1  clock
- rst  in  1  reset rst, asynchronous, active-high; clock clk
- ex_valid  in  1  EX holds a valid, non-bubble instruction
- ex_pc  in  32  PC of the EX instruction
- ex_csr_op  in  2  00 none, 01 write, 10 set, 11 clear
- ex_csr_addr  in  12  CSR address
- ex_csr_wdata  in  32  operand, already muxed between rs1 and zimm
- ex_mret  in  1  EX instruction is MRET
- ex_wfi  in  1  EX instruction is WFI
- ext_irq  in  1  external interrupt, level, asynchronous
- tmr_irq  in  1  timer interrupt, level, asynchronous
- csr_rdata  out  32  old value of the addressed CSR; 0 for unimplemented addresses
- redirect  out  1  load redirect_pc into the PC this cycle
- redirect_pc  out  32  target PC
- flush  out  1  kill IF/ID/EX contents this cycle
- stall  out  1  freeze PC, IF/ID and ID/EX

## Operation
- CSR map:
  - mstatus 0x300: MIE bit 3, MPIE bit 7, MPP [12:11] hardwired 2'b11, all other bits read 0.
  - mie 0x304: MTIE bit 7, MEIE bit 11, both writable.
  - mtvec 0x305: read-only, returns MTVEC_BASE.
  - mepc 0x341: writable; bits [1:0] are always 0.
  - mcause 0x342: writable.
  - mip 0x344: read-only; MTIP bit 7 and MEIP bit 11 reflect the synchronized interrupt lines.
- CSR write arithmetic: write gives new = wdata; set gives new = old | wdata; clear gives new = old & ~wdata. The result is then masked to the writable bits.
- A CSR write commits only when ex_valid=1, state is RUN and no trap is taken this cycle.
- Interrupt inputs pass through a 2-flop synchronizer. pend = {MEIP&MEIE, MTIP&MTIE}.
- take_irq = ex_valid & MIE & |pend & (state==RUN). Priority is external over timer.
- Trap entry (take_irq):
  - mepc <= ex_pc; the EX instruction is not executed.
  - mcause <= 32'h8000_000B for external, 32'h8000_0007 for timer.
  - MPIE <= MIE, MIE <= 0.
  - redirect=1, redirect_pc=MTVEC_BASE, flush=1; next state FLUSH.
- MRET (RUN, ex_valid, ex_mret, no take_irq): MIE <= MPIE, MPIE <= 1, redirect_pc=mepc, redirect=1, flush=1; next state FLUSH.
- States and transitions:
  - RUN: normal operation.
    - ex_valid & ex_wfi & no take_irq → SLEEP.
    - trap or MRET → FLUSH.
  - SLEEP: stall=1.
    - |pend & MIE: trap with mepc = WFI PC + 4; redirect=1, flush=1 → FLUSH.
    - |pend & !MIE: stall drops, → RUN; execution resumes after the WFI.
    - Otherwise stay in SLEEP.
  - FLUSH: one cycle. No trap, no CSR write, no MRET are accepted. → RUN.
- Simultaneous events:
  - Interrupt + MRET: the interrupt wins and mepc = MRET PC.
  - Interrupt + CSR write: the write is dropped; take_irq uses the pre-write MIE.
  - Interrupt + WFI in RUN: trap taken, mepc = WFI PC.
- Reset mid-operation: state → RUN; all registers, synchronizers and outputs are cleared immediately.

## Timing
- Reset values: mstatus=32'h0000_1800, mie=0, mepc=0, mcause=0, synchronizers=0, state=RUN.
- Output reset values: redirect=0, flush=0, stall=0, redirect_pc=0, csr_rdata=0.
- csr_rdata, redirect, redirect_pc, flush and stall are combinational from current state and inputs.
- CSR write results are visible on csr_rdata the cycle after the write.
- An interrupt line change is visible in mip and pend 2 cycles after the clock edge that samples it.
- A trap is taken in that same cycle if the conditions hold.
- WFI: stall asserts from the cycle after the WFI is in EX. Wake occurs in the cycle pend becomes nonzero.
- After every redirect there is exactly one FLUSH cycle before the next trap can be taken.

## Test plan
- Reset, then read 0x300, 0x305, 0x341 → 32'h1800, 32'h0001_0000, 0.
- Write 0x304 = 32'hFFFF_FFFF, then clear with 32'h80 → reads 32'h800. Write mepc=32'h123 → reads 32'h120.
- MIE=1, MEIE=1, assert ext_irq while ex_pc=32'h200 is valid → 2 cycles later redirect to 32'h0001_0000, mepc=32'h200, mcause=32'h8000_000B, MIE=0, MPIE=1. Then MRET → redirect_pc=32'h200, MIE=1.
- ext_irq and tmr_irq both pending, with a CSR set of mstatus in EX that cycle → external trap taken, mstatus write dropped, next cycle (FLUSH) takes no trap.
- WFI at 32'h300 with MIE=1, then tmr_irq after 10 cycles → stall held for the sleep period, trap with mepc=32'h304, mcause=32'h8000_0007. Repeat with MIE=0 → stall drops, no redirect.
- Assert rst while in SLEEP → state RUN, stall=0, mstatus=32'h1800 in the same cycle.
